cell_pos_dbuf: RTL and testbench
================================

Name: cell_pos_dbuf

Overview:
- Double-buffered (ping-pong) position memory for one simulation cell. Successor to the single-bank cell position RAM.
- The active bank serves position reads to the force-evaluation pipeline with a fixed read latency.
- The motion-update unit appends updated particles into the shadow bank at the same time.
- A swap handshake promotes the shadow bank to active at the end of an iteration. Consumers in the position cache instantiate one per cell.

Parameters:
- DATA_WIDTH, 96, width of one position word, {posz, posy, posx}.
- PARTICLE_NUM, 220, words per bank including address 0.
- ADDR_WIDTH, 8, address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.
- READ_LATENCY, 2, cycles from accepted rd_en to rd_valid; legal values 1..4.
- INIT_COUNT, 0, particle count of bank 0 after reset (matches the init file contents).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- rd_en, input, 1, read request, accepted only when rd_ready=1.
- rd_ready, output, 1, high in IDLE state only.
- rd_addr, input, ADDR_WIDTH, read address; 0 = count word, 1..count = particles.
- rd_data, output, DATA_WIDTH, read result, qualified by rd_valid.
- rd_valid, output, 1, one-cycle pulse per accepted read.
- wr_valid, input, 1, append request into the shadow bank.
- wr_data, input, DATA_WIDTH, particle position to append.
- wr_ready, output, 1, IDLE and shadow_count < PARTICLE_NUM-1.
- swap_req, input, 1, level or pulse; requests bank swap.
- swap_done, output, 1, one-cycle pulse when the swap completes.
- active_count, output, ADDR_WIDTH, particles in the active bank.
- shadow_count, output, ADDR_WIDTH, particles appended to the shadow bank.
- overflow, output, 1, sticky; set when an append is dropped.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - bank_sel=0, active_count=INIT_COUNT, shadow_count=0.
  - state=IDLE, rd_valid=0, rd_data=0, swap_done=0, overflow=0.
  - RAM contents are not cleared.
- Storage: two RAM banks of PARTICLE_NUM x DATA_WIDTH, inferred as M20K.
- Reads:
  - A read is accepted on rd_en & rd_ready.
  - rd_valid asserts exactly READ_LATENCY cycles later. Reads are fully pipelined, one per cycle.
  - rd_addr=0 returns active_count, zero-extended to DATA_WIDTH.
  - rd_addr in 1..active_count returns the stored word.
  - rd_addr > active_count returns all zeros (force-to-zero behaviour). rd_valid still pulses.
  - active_count is sampled at the accept cycle.
- Appends:
  - An append is accepted on wr_valid & wr_ready.
  - The word is written to shadow bank address shadow_count+1, and shadow_count increments in the same edge.
  - When wr_valid=1 and wr_ready=0 while in IDLE because the shadow bank is full, the word is dropped and overflow is set.
  - Outside IDLE, wr_valid is ignored with no overflow.
- FSM states: IDLE, DRAIN, SWAP.
  - IDLE -> DRAIN on swap_req=1.
  - DRAIN -> SWAP when the read pipeline holds no in-flight reads. There is a per-stage valid shift register.
  - SWAP lasts one cycle:
    - bank_sel toggles.
    - active_count <= shadow_count.
    - shadow_count <= 0.
    - swap_done=1 for that cycle.
    - Then -> IDLE.
  - The old active bank's contents become stale. They are not cleared; they are overwritten by later appends.
- Simultaneous events:
  - rd_en, wr_valid and swap_req in the same IDLE cycle: the read and the append are both accepted.
  - The append is included in the new active bank.
  - The read completes before the swap.
- Minimum swap length: DRAIN plus SWAP, at least 2 cycles after swap_req. Worst case is READ_LATENCY+1 cycles.
- Reset mid-operation: reset during DRAIN or SWAP aborts the swap.
  - In-flight reads are discarded, with no rd_valid.
  - All state returns to the reset values.
- Counter widths: counts saturate logically at PARTICLE_NUM-1 via wr_ready; no wrap-around is possible.

Test Plan:
- Reset, INIT_COUNT=5: read addr 0 -> rd_valid 2 cycles later, rd_data=5. Read addr 3 -> init-file word 3. Read addr 6 -> rd_data=0.
- Back-to-back reads addr 1,2,3,4 on consecutive cycles -> four consecutive rd_valid pulses starting cycle 2, data in order.
- Append 3 words A,B,C, then swap_req -> swap_done pulse, active_count=3, shadow_count=0. Read addr 1..3 returns A,B,C; addr 0 returns 3.
- Read at cycle t with swap_req at t -> rd_valid at t+2 carries old-bank data. swap_done at t+3. rd_ready low during t+1..t+3.
- Append PARTICLE_NUM-1=219 words -> wr_ready falls. A 220th wr_valid -> overflow=1, shadow_count stays 219.
- Assert rst_n low during DRAIN -> no rd_valid, bank_sel=0, active_count=INIT_COUNT, overflow=0, FSM in IDLE.

Source files
------------

// File: rtl/cell_pos_dbuf.sv
// Ping-pong position memory for one simulation cell.
// The active bank serves pipelined position reads to the force pipeline.
// The shadow bank collects appended particles from the motion-update unit.
// A swap handshake first drains the read pipeline, then promotes the shadow
// bank to active.
module cell_pos_dbuf #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int INIT_COUNT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] INIT_CNT  = ADDR_WIDTH'(INIT_COUNT);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

    // Storage banks; contents are never cleared, stale words get overwritten.
    logic [DATA_WIDTH-1:0] bank0_mem [PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] bank1_mem [PARTICLE_NUM];

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    bank_sel_r;
    logic [ADDR_WIDTH-1:0]   active_count_r;
    logic [ADDR_WIDTH-1:0]   shadow_count_r;
    logic                    overflow_r;
    logic                    swap_done_r;
    logic [READ_LATENCY-1:0] pipe_vld_r;
    logic [DATA_WIDTH-1:0]   pipe_data_r [READ_LATENCY];

    logic                    idle_s;
    logic                    has_room_s;
    logic                    rd_acc_s;
    logic                    wr_acc_s;
    logic                    wr_drop_s;
    logic                    pipe_busy_s;
    logic                    swap_go_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [ADDR_WIDTH-1:0]   rd_idx_s;
    logic [DATA_WIDTH-1:0]   ram_word_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    // Handshake decode, append address and read-result selection.
    always_comb begin
        idle_s     = (state_r == ST_IDLE);
        has_room_s = (shadow_count_r < COUNT_MAX);
        rd_acc_s   = rd_en & idle_s;
        wr_acc_s   = wr_valid & idle_s & has_room_s;
        wr_drop_s  = wr_valid & idle_s & ~has_room_s;
        wr_addr_s  = shadow_count_r + ADDR_WIDTH'(1);
        // Addresses past the array end are never returned; clamp the index.
        if ({1'b0, rd_addr} < DEPTH_EXT) begin
            rd_idx_s = rd_addr;
        end else begin
            rd_idx_s = '0;
        end
        if (bank_sel_r) begin
            ram_word_s = bank1_mem[rd_idx_s];
        end else begin
            ram_word_s = bank0_mem[rd_idx_s];
        end
        // Address 0 is the count word; beyond the count reads as zero.
        if (rd_addr == '0) begin
            rd_word_s = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, active_count_r};
        end else if (rd_addr <= active_count_r) begin
            rd_word_s = ram_word_s;
        end else begin
            rd_word_s = '0;
        end
    end

    // In-flight detection: the last stage is being presented this cycle, so
    // only the earlier stages hold reads that would complete after a swap.
    always_comb begin
        pipe_busy_s = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe_busy_s = pipe_busy_s | pipe_vld_r[i];
        end
        swap_go_s = (state_r == ST_DRAIN) & ~pipe_busy_s;
    end

    // Swap FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (swap_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (swap_go_s) begin
                    state_nxt_s = ST_SWAP;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_SWAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, bank selection, counters and sticky overflow; the bank flip and
    // count hand-over take effect on entry to SWAP, alongside swap_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            bank_sel_r     <= 1'b0;
            active_count_r <= INIT_CNT;
            shadow_count_r <= '0;
            overflow_r     <= 1'b0;
            swap_done_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            swap_done_r <= swap_go_s;
            if (swap_go_s) begin
                bank_sel_r     <= ~bank_sel_r;
                active_count_r <= shadow_count_r;
                shadow_count_r <= '0;
            end else if (wr_acc_s) begin
                shadow_count_r <= wr_addr_s;
            end
            if (wr_drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Bank 0 write port: used while bank 1 is active.
    always_ff @(posedge clk) begin
        if (wr_acc_s && bank_sel_r) begin
            bank0_mem[wr_addr_s] <= wr_data;
        end
    end

    // Bank 1 write port: used while bank 0 is active.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !bank_sel_r) begin
            bank1_mem[wr_addr_s] <= wr_data;
        end
    end

    // Read pipeline: result captured at accept, then delayed to the latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= rd_acc_s;
            pipe_data_r[0] <= rd_acc_s ? rd_word_s : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    assign rd_ready     = idle_s;
    assign wr_ready     = idle_s & has_room_s;
    assign rd_valid     = pipe_vld_r[READ_LATENCY-1];
    assign rd_data      = pipe_data_r[READ_LATENCY-1];
    assign swap_done    = swap_done_r;
    assign active_count = active_count_r;
    assign shadow_count = shadow_count_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_cell_pos_dbuf.sv
// Scoreboard bench for cell_pos_dbuf: reads push expected data and arrival
// cycle, a monitor pops and compares on every rd_valid pulse.
module tb_cell_pos_dbuf;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int RL = 2;
    localparam int IC = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          swap_req;
    logic          swap_done;
    logic [AW-1:0] active_count;
    logic [AW-1:0] shadow_count;
    logic          overflow;

    cell_pos_dbuf #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .INIT_COUNT  (IC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .active_count(active_count),
        .shadow_count(shadow_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   vcount     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] wd(input int i);
        return {32'(i), 32'hC0DE_0000 | 32'(i), 32'(i * 7 + 3)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rd_valid) begin
            vcount++;
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rd_valid: got data %h expected no pulse", rd_data);
            end else begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_cycle", 96'(cyc), 96'(e.cyc));
            end
        end
    end

    // All drivers run at the negedge; the read is accepted at the next posedge.
    task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = a;
        e.data  = exp;
        e.cyc   = cyc + RL;
        q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr1(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_swap(input logic [AW-1:0] exp_active);
        bit seen;
        seen     = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (swap_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("swap_done_seen", 96'(seen), 96'(1));
        chk("swap_active_count", 96'(active_count), 96'(exp_active));
        chk("swap_shadow_count", 96'(shadow_count), 96'(0));
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int vsnap;
        rst_n    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_data  = '0;
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        chk("rst_rd_valid", 96'(rd_valid), 96'(0));
        chk("rst_rd_data", rd_data, 96'(0));
        chk("rst_active_count", 96'(active_count), 96'(IC));
        chk("rst_shadow_count", 96'(shadow_count), 96'(0));
        chk("rst_overflow", 96'(overflow), 96'(0));
        chk("rst_swap_done", 96'(swap_done), 96'(0));
        chk("rst_rd_ready", 96'(rd_ready), 96'(1));
        chk("rst_wr_ready", 96'(wr_ready), 96'(1));

        // Count word and force-to-zero beyond the count.
        rd1(8'd0, 96'(IC));
        rd1(8'd6, 96'(0));
        rd1(8'd200, 96'(0));
        repeat (4) @(negedge clk);

        // Fill shadow bank 1 with A..D and promote it.
        for (int i = 1; i <= 4; i++) wr1(wd(i));
        chk("append_shadow_count", 96'(shadow_count), 96'(4));
        do_swap(8'd4);

        // Back-to-back reads; monitor checks order and one-per-cycle arrival.
        rd1(8'd1, wd(1));
        rd1(8'd2, wd(2));
        rd1(8'd3, wd(3));
        rd1(8'd4, wd(4));
        rd1(8'd0, 96'(4));
        rd1(8'd5, 96'(0));
        repeat (4) @(negedge clk);

        // Append E,F,G into bank 0, then read + append H + swap_req together.
        for (int i = 5; i <= 7; i++) wr1(wd(i));
        t = cyc;
        begin
            exp_t e;
            e.data = wd(2);
            e.cyc  = t + RL;
            q.push_back(e);
        end
        rd_en    = 1'b1;
        rd_addr  = 8'd2;
        wr_valid = 1'b1;
        wr_data  = wd(8);
        swap_req = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        chk("sim_t1_rd_ready", 96'(rd_ready), 96'(0));
        chk("sim_t1_swap_done", 96'(swap_done), 96'(0));
        chk("sim_t1_shadow_count", 96'(shadow_count), 96'(4));
        @(negedge clk);
        chk("sim_t2_rd_ready", 96'(rd_ready), 96'(0));
        chk("sim_t2_swap_done", 96'(swap_done), 96'(0));
        @(negedge clk);
        chk("sim_t3_rd_ready", 96'(rd_ready), 96'(0));
        chk("sim_t3_swap_done", 96'(swap_done), 96'(1));
        chk("sim_t3_active_count", 96'(active_count), 96'(4));
        chk("sim_t3_shadow_count", 96'(shadow_count), 96'(0));
        @(negedge clk);
        chk("sim_t4_rd_ready", 96'(rd_ready), 96'(1));
        chk("sim_t4_swap_done", 96'(swap_done), 96'(0));
        rd1(8'd0, 96'(4));
        rd1(8'd1, wd(5));
        rd1(8'd2, wd(6));
        rd1(8'd3, wd(7));
        rd1(8'd4, wd(8));
        repeat (4) @(negedge clk);

        // Fill bank 1 to capacity, then one dropped append.
        for (int i = 1; i <= PN - 1; i++) wr1(wd(1000 + i));
        chk("full_shadow_count", 96'(shadow_count), 96'(PN - 1));
        chk("full_wr_ready", 96'(wr_ready), 96'(0));
        chk("full_overflow_pre", 96'(overflow), 96'(0));
        wr1(wd(9999));
        chk("drop_overflow", 96'(overflow), 96'(1));
        chk("drop_shadow_count", 96'(shadow_count), 96'(PN - 1));
        do_swap(8'(PN - 1));
        chk("post_swap_overflow_sticky", 96'(overflow), 96'(1));
        rd1(8'd1, wd(1001));
        rd1(8'(PN - 1), wd(1000 + PN - 1));
        rd1(8'(PN), 96'(0));
        rd1(8'd255, 96'(0));
        rd1(8'd0, 96'(PN - 1));
        repeat (4) @(negedge clk);

        // Reset during DRAIN with a read in flight: no rd_valid may appear.
        vsnap    = vcount;
        rd_en    = 1'b1;
        rd_addr  = 8'd1;
        swap_req = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
        swap_req = 1'b0;
        chk("drain_rd_ready", 96'(rd_ready), 96'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 96'(rd_valid), 96'(0));
        chk("mid_rst_active_count", 96'(active_count), 96'(IC));
        chk("mid_rst_shadow_count", 96'(shadow_count), 96'(0));
        chk("mid_rst_overflow", 96'(overflow), 96'(0));
        chk("mid_rst_rd_ready", 96'(rd_ready), 96'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_valid", 96'(vcount), 96'(vsnap));
        chk("mid_rst_swap_done", 96'(swap_done), 96'(0));
        // Bank 0 is active again and still holds E..H.
        rd1(8'd0, 96'(IC));
        rd1(8'd1, wd(5));
        rd1(8'd4, wd(8));
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", 96'(q.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
